// File: rtl/upc_display_sequencer.sv
// upc_display_sequencer
//   Drives the item-name HEX display of the UPC checker. An accepted scan is
//   shown for HOLD_TICKS display ticks. A stolen item then blinks
//   (blank first) for ALERT_BLINKS blank/show pairs before the display goes
//   blank. A scan that arrives while an item is on display can be held in a
//   one-deep pending slot and is shown next without an idle gap.
//
//   Build option: define UPC_SEQ_PENDING_EN to enable the pending slot.
//   Without it, every valid scan that arrives while busy is dropped and
//   raises overflow.
//
// Ports
//   clk_i         system clock, rising edge
//   reset_n_i     asynchronous active-low reset
//   upc_valid_i   one-cycle scan strobe
//   upc_code_i    item code; valid codes are 0,1,3,4,5,6
//   upc_stolen_i  stolen flag, sampled with upc_valid_i
//   upc_disc_i    discount flag, sampled with upc_valid_i
//   bcd_o         code to the item identifier, 4'hF = blank
//   led_stolen_o  item on display is stolen
//   led_disc_o    item on display is discounted
//   busy_o        an item is on display (SHOW or ALERT)
//   err_o         one-cycle pulse after a scan with an invalid code
//   overflow_o    sticky: a valid scan was dropped; cleared only by reset
module upc_display_sequencer #(
    parameter int TICK_DIV     = 50_000_000,
    parameter int HOLD_TICKS   = 3,
    parameter int BLINK_TICKS  = 1,
    parameter int ALERT_BLINKS = 3
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       upc_valid_i,
    input  logic [3:0] upc_code_i,
    input  logic       upc_stolen_i,
    input  logic       upc_disc_i,
    output logic [3:0] bcd_o,
    output logic       led_stolen_o,
    output logic       led_disc_o,
    output logic       busy_o,
    output logic       err_o,
    output logic       overflow_o
);
    localparam int PHASES   = 2 * ALERT_BLINKS;
    localparam int TICK_MAX = (HOLD_TICKS > BLINK_TICKS) ? HOLD_TICKS : BLINK_TICKS;
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int PH_W     = $clog2(PHASES);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] HOLD_LAST  = TICK_W'(HOLD_TICKS - 1);
    localparam logic [TICK_W-1:0] BLINK_LAST = TICK_W'(BLINK_TICKS - 1);
    localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(PHASES - 1);
    localparam logic [3:0]        BLANK      = 4'hF;

    typedef enum logic [1:0] {IDLE, SHOW, ALERT} state_e;

    typedef struct packed {
        logic [3:0] code;
        logic       stolen;
        logic       disc;
    } item_t;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    item_t             item_q, item_d, scan;
`ifdef UPC_SEQ_PENDING_EN
    item_t             pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
`endif
    logic [3:0]        bcd_q, bcd_d;
    logic              led_stolen_q, led_stolen_d, led_disc_q, led_disc_d;
    logic              busy_q, busy_d, err_q, err_d, overflow_q, overflow_d;

    logic code_ok, scan_ok, tick_end, hold_end, phase_end, item_end, restart;

    always_comb begin
        code_ok   = upc_code_i inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6};
        scan_ok   = upc_valid_i && code_ok;
        scan      = '{code: upc_code_i, stolen: upc_stolen_i, disc: upc_disc_i};
        tick_end  = (div_q == DIV_LAST);
        hold_end  = (state_q == SHOW) && tick_end && (tick_q == HOLD_LAST);
        phase_end = (state_q == ALERT) && tick_end && (tick_q == BLINK_LAST);
        // The item is finished: a non-stolen SHOW, or the final ALERT phase.
        item_end  = (hold_end && !item_q.stolen) || (phase_end && (phase_q == PH_LAST));

        state_d    = state_q;
        item_d     = item_q;
`ifdef UPC_SEQ_PENDING_EN
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
`endif
        overflow_d = overflow_q;
        err_d      = upc_valid_i && !code_ok;
        restart    = 1'b0;

        // Cycle divider -> tick counter -> blink phase counter.
        div_d   = tick_end ? '0 : div_q + 1'b1;
        tick_d  = tick_end ? tick_q + 1'b1 : tick_q;
        phase_d = phase_q;
        if (phase_end) begin
            tick_d  = '0;
            phase_d = phase_q + 1'b1;
        end

        case (state_q)
            IDLE: if (scan_ok) begin
                state_d = SHOW;
                item_d  = scan;
                restart = 1'b1;
            end
            SHOW: if (hold_end && item_q.stolen) begin
                state_d = ALERT;
                restart = 1'b1;
            end
            default: ;
        endcase

        if (state_q != IDLE) begin
`ifdef UPC_SEQ_PENDING_EN
            if (item_end) begin
                restart = 1'b1;
                if (pend_vld_q) begin
                    // Pending item goes on display; a scan in this same
                    // cycle takes over the slot just freed.
                    state_d    = SHOW;
                    item_d     = pend_q;
                    pend_vld_d = scan_ok;
                    if (scan_ok) pend_d = scan;
                end else if (scan_ok) begin
                    // Scan on the last cycle: slot fills and drains at once.
                    state_d = SHOW;
                    item_d  = scan;
                end else begin
                    state_d = IDLE;
                end
            end else if (scan_ok) begin
                if (!pend_vld_q) begin
                    pend_vld_d = 1'b1;
                    pend_d     = scan;
                end else begin
                    overflow_d = 1'b1;
                end
            end
`else
            if (item_end) begin
                restart = 1'b1;
                state_d = IDLE;
            end
            if (scan_ok) overflow_d = 1'b1;
`endif
        end

        // Durations are exact: every state entry starts counting from zero.
        if (restart || state_d == IDLE) begin
            div_d   = '0;
            tick_d  = '0;
            phase_d = '0;
        end

        // Outputs follow the next state so they change with it.
        case (state_d)
            SHOW:    bcd_d = item_d.code;
            ALERT:   bcd_d = phase_d[0] ? item_d.code : BLANK;
            default: bcd_d = BLANK;
        endcase
        busy_d       = (state_d != IDLE);
        led_stolen_d = busy_d && item_d.stolen;
        led_disc_d   = busy_d && item_d.disc;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            div_q        <= '0;
            tick_q       <= '0;
            phase_q      <= '0;
            item_q       <= '0;
`ifdef UPC_SEQ_PENDING_EN
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
`endif
            bcd_q        <= BLANK;
            led_stolen_q <= 1'b0;
            led_disc_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            tick_q       <= tick_d;
            phase_q      <= phase_d;
            item_q       <= item_d;
`ifdef UPC_SEQ_PENDING_EN
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
`endif
            bcd_q        <= bcd_d;
            led_stolen_q <= led_stolen_d;
            led_disc_q   <= led_disc_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bcd_o        = bcd_q;
    assign led_stolen_o = led_stolen_q;
    assign led_disc_o   = led_disc_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;
    assign overflow_o   = overflow_q;
endmodule

// File: tb/tb_upc_display_sequencer.sv
// Bench for upc_display_sequencer: a table of single scans from idle, a few
// hand-written multi-cycle sequences, and random traffic, all compared
// cycle by cycle against a timeline model of the display.
module tb_upc_display_sequencer;
    localparam int TD = 2, HT = 3, BT = 1, AB = 2;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       v = 1'b0, st = 1'b0, di = 1'b0;
    logic [3:0] code = 4'd0;
    logic [3:0] bcd;
    logic       ls, ld, busy, err, ovf;

    int n_tests = 0, n_fail = 0;

    upc_display_sequencer #(.TICK_DIV(TD), .HOLD_TICKS(HT), .BLINK_TICKS(BT),
                            .ALERT_BLINKS(AB)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .upc_valid_i(v), .upc_code_i(code),
        .upc_stolen_i(st), .upc_disc_i(di), .bcd_o(bcd), .led_stolen_o(ls),
        .led_disc_o(ld), .busy_o(busy), .err_o(err), .overflow_o(ovf));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---- reference model: an item is a timeline of t = 0 .. dur-1 cycles ----
    typedef struct packed {logic [3:0] code; logic st; logic di;} it_t;
    it_t m_item;
    it_t m_pend[$];
    bit  m_act, m_err, m_ovf;
    int  m_t;

    function automatic bit code_ok(input logic [3:0] c);
        return (c == 0) || (c == 1) || (c == 3) || (c == 4) || (c == 5) || (c == 6);
    endfunction

    function automatic int dur(input it_t i);
        return HT * TD + (i.st ? 2 * AB * BT * TD : 0);
    endfunction

    function automatic logic [3:0] m_bcd();
        if (!m_act) return 4'hF;
        if (m_t < HT * TD) return m_item.code;
        return (((m_t - HT * TD) / (BT * TD)) % 2 == 0) ? 4'hF : m_item.code;
    endfunction

    function automatic logic [8:0] m_vec();
        return {m_bcd(), m_act && m_item.st, m_act && m_item.di, m_act, m_err, m_ovf};
    endfunction

    task automatic model_reset();
        m_act = 0; m_err = 0; m_ovf = 0; m_t = 0; m_item = '0;
        m_pend.delete();
    endtask

    task automatic model_step(input bit vv, input logic [3:0] c, input bit s, input bit d);
        bit  ok, ending;
        it_t sc;
        ok = vv && code_ok(c);
        sc = '{code: c, st: s, di: d};
        m_err = vv && !code_ok(c);
        if (!m_act) begin
            if (ok) begin m_act = 1; m_item = sc; m_t = 0; end
        end else begin
            ending = (m_t + 1 == dur(m_item));
            if (ok) begin
`ifdef UPC_SEQ_PENDING_EN
                if (m_pend.size() == 0 || ending) m_pend.push_back(sc);
                else m_ovf = 1;
`else
                m_ovf = 1;
`endif
            end
            if (ending) begin
                if (m_pend.size() > 0) begin m_item = m_pend.pop_front(); m_t = 0; end
                else m_act = 0;
            end else begin
                m_t++;
            end
        end
    endtask

    // ---- checking helpers ----
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare against the model.
    task automatic step(input bit vv, input logic [3:0] c, input bit s, input bit d);
        v = vv; code = c; st = s; di = d;
        @(posedge clk);
        model_step(vv, c, s, d);
        #1;
        v = 0;
        chk("model {bcd,ls,ld,busy,err,ovf}", {bcd, ls, ld, busy, err, ovf}, m_vec());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'd0, 0, 0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (m_act && k < 60) begin step(0, 4'd0, 0, 0); k++; end
        chk("drain to idle", busy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        #1;
        model_reset();
        chk("reset outputs", {bcd, ls, ld, busy, err, ovf}, {4'hF, 5'b0});
        @(negedge clk);
        rst_n = 1;
    endtask

    typedef struct {
        bit v; logic [3:0] code; bit st; bit di;
        logic [3:0] e_bcd; bit e_busy; bit e_err; bit e_ls; bit e_ld;
    } vec_t;
    vec_t tbl[10];

    logic [3:0] exp_tr[15];

    initial begin
        tbl[0] = '{1, 4'd4,  0, 1, 4'd4, 1, 0, 0, 1};
        tbl[1] = '{1, 4'd0,  1, 0, 4'd0, 1, 0, 1, 0};
        tbl[2] = '{1, 4'd2,  0, 0, 4'hF, 0, 1, 0, 0};
        tbl[3] = '{1, 4'd9,  1, 1, 4'hF, 0, 1, 0, 0};
        tbl[4] = '{1, 4'd6,  1, 1, 4'd6, 1, 0, 1, 1};
        tbl[5] = '{0, 4'd3,  1, 1, 4'hF, 0, 0, 0, 0};
        tbl[6] = '{1, 4'd15, 0, 0, 4'hF, 0, 1, 0, 0};
        tbl[7] = '{1, 4'd1,  0, 0, 4'd1, 1, 0, 0, 0};
        tbl[8] = '{1, 4'd3,  0, 1, 4'd3, 1, 0, 0, 1};
        tbl[9] = '{1, 4'd5,  1, 0, 4'd5, 1, 0, 1, 0};
        exp_tr = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'hF, 4'hF,
                   4'd0, 4'd0, 4'hF, 4'hF, 4'd0, 4'd0, 4'hF};

        // Reset state while reset is held.
        model_reset();
        #12;
        chk("reset outputs", {bcd, ls, ld, busy, err, ovf}, {4'hF, 5'b0});
        @(negedge clk);
        rst_n = 1;

        // Table: one scan from idle, check the first registered outputs.
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].code, tbl[i].st, tbl[i].di);
            chk($sformatf("tbl[%0d] {bcd,busy,err,ls,ld}", i), {bcd, busy, err, ls, ld},
                {tbl[i].e_bcd, tbl[i].e_busy, tbl[i].e_err, tbl[i].e_ls, tbl[i].e_ld});
            drain();
            idle(1);
            chk($sformatf("tbl[%0d] overflow", i), ovf, 1'b0);
        end

        // Stolen item: 6 cycles of code, blank/code blinking, then idle.
        step(1, 4'd0, 1, 0);
        chk("stolen trace bcd[0]", bcd, exp_tr[0]);
        for (int i = 1; i < 15; i++) begin
            step(0, 4'd0, 0, 0);
            chk($sformatf("stolen trace bcd[%0d]", i), bcd, exp_tr[i]);
            chk($sformatf("stolen trace led[%0d]", i), {ls, busy}, (i < 14) ? 2'b11 : 2'b00);
        end

        // Second scan at cycle 2 and a third at cycle 3 while SHOW is running.
        do_reset();
        step(1, 4'd1, 0, 0);
        step(0, 4'd0, 0, 0);
        step(1, 4'd5, 0, 0);
        step(1, 4'd6, 0, 0);
        chk("third scan overflow", ovf, 1'b1);
        idle(2);
        chk("first item last cycle", bcd, 4'd1);
        step(0, 4'd0, 0, 0);
`ifdef UPC_SEQ_PENDING_EN
        chk("pending item no gap", {bcd, busy}, {4'd5, 1'b1});
        idle(5);
        chk("pending item last cycle", bcd, 4'd5);
        step(0, 4'd0, 0, 0);
`endif
        chk("idle after items", {bcd, busy}, {4'hF, 1'b0});
        drain();

        // Second scan lands on SHOW's last cycle.
        do_reset();
        step(1, 4'd1, 0, 0);
        idle(5);
        step(1, 4'd5, 0, 1);
`ifdef UPC_SEQ_PENDING_EN
        chk("last-cycle scan shown", {bcd, ld, ovf}, {4'd5, 1'b1, 1'b0});
`else
        chk("last-cycle scan dropped", {bcd, busy, ovf}, {4'hF, 1'b0, 1'b1});
`endif
        drain();

        // Asynchronous reset in the middle of ALERT.
        do_reset();
        step(1, 4'd0, 1, 1);
        idle(8);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk("async reset mid-ALERT", {bcd, ls, ld, busy, err, ovf}, {4'hF, 5'b0});
        @(negedge clk);
        rst_n = 1;
        step(1, 4'd4, 0, 1);
        chk("scan after reset", {bcd, ld, busy}, {4'd4, 1'b1, 1'b1});
        drain();

        // Random traffic against the model, reset periodically.
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 399) do_reset();
            step(($urandom % 5) == 0, 4'($urandom % ((i % 3 == 0) ? 16 : 8)),
                 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
